// File: rtl/afe_config_sequencer.sv
// Walks the AFE command ROM from address 0 and sends each 24-bit word over SPI mode 0, MSB first.
// Optional feature macro: AFE_CFG_DELAY_EN turns 8'hFE,N[15:0] words into N-clock pauses instead of frames.
module afe_config_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_address,
    input  logic [23:0] rom_command,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  word_count,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_SHIFT  = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;
    localparam logic [2:0] ST_DELAY  = 3'd6;
    localparam logic [2:0] ST_FINISH = 3'd7;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
    localparam logic [5:0]  HALF_END = 6'd48;

    logic [2:0]  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [23:0] shreg_q, shreg_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  half_q, half_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [7:0]  wc_q, wc_d;
    logic        advance;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        wc_d    = wc_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = 8'd0;
                    wc_d    = 8'd0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_command == 24'hFFFFFF) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end
`ifdef AFE_CFG_DELAY_EN
                else if (rom_command[23:16] == 8'hFE) begin
                    if (rom_command[15:0] == 16'd0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d   = rom_command[15:0] - 16'd1;
                        state_d = ST_DELAY;
                    end
                end
`endif
                else begin
                    shreg_d = rom_command;
                    mosi_d  = rom_command[23];
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    cnt_d   = 16'd0;
                    half_d  = 6'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // 48 half periods of SCLK, then one more half period of CS hold before release.
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 16'd0;
                    if (half_q == HALF_END) begin
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = ST_GAP;
                        if (wc_q != 8'hFF) begin
                            wc_d = wc_q + 8'd1;
                        end
                    end else begin
                        half_d = half_q + 6'd1;
                        sclk_d = ~sclk_q;
                        if (sclk_q) begin
                            shreg_d = {shreg_q[22:0], 1'b0};
                            mosi_d  = shreg_q[22];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef AFE_CFG_DELAY_EN
            ST_DELAY: begin
                if (cnt_q == 16'd0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            ST_FINISH: begin
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Running off the top of the ROM is an error; the address never wraps.
        if (advance) begin
            cnt_d = 16'd0;
            if (addr_q == 8'hFF) begin
                error_d = 1'b1;
                state_d = ST_FINISH;
            end else begin
                addr_d  = addr_q + 8'd1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            shreg_q <= 24'd0;
            cnt_q   <= 16'd0;
            half_q  <= 6'd0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            wc_q    <= wc_d;
        end
    end

    assign rom_address = addr_q;
    assign spi_sclk    = sclk_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_mosi    = mosi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_count  = wc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_afe_config_sequencer.sv
// Bench for afe_config_sequencer: ROM model, SPI frame monitor, vector table plus hand-written corner sequences.
module tb_afe_config_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int CS_GAP    = 8;
    localparam int FRAME_LOW = 49 * CLK_DIV;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rom_address;
    logic [23:0] rom_command;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  word_count;
    logic [2:0]  dbg_state;

    afe_config_sequencer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_address(rom_address), .rom_command(rom_command),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .busy(busy), .done(done), .error(error),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [23:0] rom [256];
    always @(posedge clk) rom_command <= rom[rom_address];

    // SPI monitor: rebuilds each frame as seen by the AFE (sampled on SCLK rise while CS low)
    int          cyc = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [23:0] mon_sh = '0;
    int          mon_bits = 0;
    int          mon_low = 0;
    int          mon_high = 0;
    logic [23:0] got_w[$];
    int          got_b[$];
    int          got_len[$];
    int          fall_cyc[$];
    int          gap_before[$];

    always @(negedge clk) begin
        cyc++;
        if (!spi_cs_n) begin
            if (prev_cs) begin
                mon_bits = 0;
                mon_sh   = '0;
                mon_low  = 0;
                fall_cyc.push_back(cyc);
                gap_before.push_back(mon_high);
            end
            mon_low++;
            if (spi_sclk && !prev_sclk) begin
                mon_sh = {mon_sh[22:0], spi_mosi};
                mon_bits++;
            end
        end else begin
            if (!prev_cs) begin
                got_w.push_back(mon_sh);
                got_b.push_back(mon_bits);
                got_len.push_back(mon_low);
                mon_high = 0;
            end
            mon_high++;
        end
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    // scoreboard
    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_ge(input string name, input int got, input int lim);
        checks++;
        if (got < lim) begin
            failures++;
            $display("FAIL %s: got %0d expected >= %0d", name, got, lim);
        end
    endtask

    // driver tasks
    task automatic load_rom(input logic [23:0] fill, input logic [23:0] w0,
                            input logic [23:0] w1, input logic [23:0] w2);
        for (int i = 0; i < 256; i++) rom[i] = fill;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input logic spam);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            start = spam && busy && (n % 50 == 7);
            n++;
        end
        start = 1'b0;
        check("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [23:0] w0, w1, w2;
        int          nf;
        logic [23:0] f0, f1;
        logic        spam;
        int          min_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        int start_cyc;
        string tag;
        tag = $sformatf("v%0d", idx);
        load_rom(24'hFFFFFF, v.w0, v.w1, v.w2);
        exp_q.delete();
        if (v.nf >= 1) exp_q.push_back(v.f0);
        if (v.nf >= 2) exp_q.push_back(v.f1);
        base = got_w.size();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        wait_idle(5000, v.spam);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_word_count"}, {24'd0, word_count}, 32'(v.nf));
        check({tag, "_idle_lines"}, {29'd0, spi_cs_n, spi_sclk, spi_mosi}, 32'h4);
        check({tag, "_frames"}, 32'(got_w.size() - base), 32'(v.nf));
        for (int i = base; i < got_w.size() && exp_q.size() > 0; i++) begin
            check({tag, "_frame_word"}, {8'd0, got_w[i]}, {8'd0, exp_q.pop_front()});
            check({tag, "_frame_bits"}, 32'(got_b[i]), 32'd24);
            check({tag, "_cs_low_len"}, 32'(got_len[i]), 32'(FRAME_LOW));
            if (i > base) check_ge({tag, "_cs_gap"}, gap_before[i], CS_GAP);
        end
        if (v.min_lat > 0 && fall_cyc.size() > base)
            check_ge({tag, "_delay_latency"}, fall_cyc[base] - start_cyc, v.min_lat);
    endtask

    initial begin
        int base;
        int k;
        int bad;
        logic done_seen;

        vecs[0] = '{w0: 24'h000102, w1: 24'hFFFFFF, w2: 24'hFFFFFF, nf: 1,
                    f0: 24'h000102, f1: 24'h0, spam: 1'b0, min_lat: 0};
        vecs[1] = '{w0: 24'hFFFFFF, w1: 24'hFFFFFF, w2: 24'hFFFFFF, nf: 0,
                    f0: 24'h0, f1: 24'h0, spam: 1'b0, min_lat: 0};
`ifdef AFE_CFG_DELAY_EN
        vecs[2] = '{w0: 24'hFE0064, w1: 24'hAABBCC, w2: 24'hFFFFFF, nf: 1,
                    f0: 24'hAABBCC, f1: 24'h0, spam: 1'b0, min_lat: 100};
        vecs[4] = '{w0: 24'hFE0000, w1: 24'hA5A5A5, w2: 24'hFFFFFF, nf: 1,
                    f0: 24'hA5A5A5, f1: 24'h0, spam: 1'b0, min_lat: 0};
`else
        vecs[2] = '{w0: 24'hFE0064, w1: 24'hAABBCC, w2: 24'hFFFFFF, nf: 2,
                    f0: 24'hFE0064, f1: 24'hAABBCC, spam: 1'b0, min_lat: 0};
        vecs[4] = '{w0: 24'hFE0000, w1: 24'hA5A5A5, w2: 24'hFFFFFF, nf: 2,
                    f0: 24'hFE0000, f1: 24'hA5A5A5, spam: 1'b0, min_lat: 0};
`endif
        vecs[3] = '{w0: 24'h000102, w1: 24'h0A0B0C, w2: 24'hFFFFFF, nf: 2,
                    f0: 24'h000102, f1: 24'h0A0B0C, spam: 1'b1, min_lat: 0};

        start = 1'b0;
        reset = 1'b1;
        load_rom(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_lines", {29'd0, spi_cs_n, spi_sclk, spi_mosi}, 32'h4);
        check("reset_flags", {29'd0, busy, done, error}, 32'h0);
        check("reset_word_count", {24'd0, word_count}, 32'd0);
        check("reset_address", {24'd0, rom_address}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // END at address 0: done must appear within 4 clocks of start
        load_rom(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        base = got_w.size();
        @(negedge clk);
        start = 1'b1;
        done_seen = 1'b0;
        for (k = 1; k <= 4 && !done_seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            done_seen = done;
        end
        check("end_done_latency", {31'd0, done_seen}, 32'd1);
        wait_idle(50, 1'b0);
        check("end_no_frame", 32'(got_w.size() - base), 32'd0);

        // reset part-way through a frame, then a clean re-run from address 0
        load_rom(24'hFFFFFF, 24'h123456, 24'hFFFFFF, 24'hFFFFFF);
        pulse_start();
        k = 0;
        while ((spi_cs_n || mon_bits < 10) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("midframe_reached", {31'd0, (k < 2000)}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_lines", {30'd0, spi_cs_n, spi_sclk}, 32'h2);
        check("midframe_reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        base = got_w.size();
        pulse_start();
        wait_idle(5000, 1'b0);
        check("rerun_frames", 32'(got_w.size() - base), 32'd1);
        if (got_w.size() > base) begin
            check("rerun_word", {8'd0, got_w[base]}, 32'h123456);
            check("rerun_bits", 32'(got_b[base]), 32'd24);
        end
        check("rerun_word_count", {24'd0, word_count}, 32'd1);
        check("rerun_done", {31'd0, done}, 32'd1);

        // no END anywhere: 256 frames, then error at address 255
        load_rom(24'h123456, 24'h123456, 24'h123456, 24'h123456);
        base = got_w.size();
        pulse_start();
        wait_idle(60000, 1'b0);
        check("norend_error", {31'd0, error}, 32'd1);
        check("norend_done", {31'd0, done}, 32'd0);
        check("norend_address", {24'd0, rom_address}, 32'd255);
        check("norend_word_count_sat", {24'd0, word_count}, 32'd255);
        check("norend_frames", 32'(got_w.size() - base), 32'd256);
        bad = 0;
        for (int i = base; i < got_w.size(); i++)
            if (got_w[i] !== 24'h123456 || got_b[i] != 24) bad++;
        check("norend_bad_frames", 32'(bad), 32'd0);
        check("norend_idle_lines", {29'd0, spi_cs_n, spi_sclk, spi_mosi}, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
